// File: rtl/reg_file_if.sv
// reg_file_if: dispatcher read/rename and RoB commit/rollback signals of the register file.
//   slave  : the register file (sees requests, drives read results)
//   master : the dispatcher/RoB side (drives requests, sees read results)
//   rs1/rs2_from_dispatcher, Q1/Q2/V1/V2_to_dispatcher : source operand read
//   en_signal/rd/rob_id_from_dispatcher                : destination rename
//   commit_flag, rd_from_rob, Q_from_rob, V_from_rob   : retire write
//   rollback_flag                                      : flush of all pending tags
interface reg_file_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
);
    localparam int unsigned IDX_W = 5;

    logic [IDX_W-1:0] rs1_from_dispatcher;
    logic [IDX_W-1:0] rs2_from_dispatcher;
    logic [TAG_W-1:0] Q1_to_dispatcher;
    logic [TAG_W-1:0] Q2_to_dispatcher;
    logic [XLEN-1:0]  V1_to_dispatcher;
    logic [XLEN-1:0]  V2_to_dispatcher;
    logic             en_signal_from_dispatcher;
    logic [IDX_W-1:0] rd_from_dispatcher;
    logic [TAG_W-1:0] rob_id_from_dispatcher;
    logic             commit_flag;
    logic [IDX_W-1:0] rd_from_rob;
    logic [TAG_W-1:0] Q_from_rob;
    logic [XLEN-1:0]  V_from_rob;
    logic             rollback_flag;

    modport slave (
        input  rs1_from_dispatcher, rs2_from_dispatcher,
        output Q1_to_dispatcher, Q2_to_dispatcher, V1_to_dispatcher, V2_to_dispatcher,
        input  en_signal_from_dispatcher, rd_from_dispatcher, rob_id_from_dispatcher,
        input  commit_flag, rd_from_rob, Q_from_rob, V_from_rob,
        input  rollback_flag
    );

    modport master (
        output rs1_from_dispatcher, rs2_from_dispatcher,
        input  Q1_to_dispatcher, Q2_to_dispatcher, V1_to_dispatcher, V2_to_dispatcher,
        output en_signal_from_dispatcher, rd_from_dispatcher, rob_id_from_dispatcher,
        output commit_flag, rd_from_rob, Q_from_rob, V_from_rob,
        output rollback_flag
    );
endinterface

// File: rtl/reg_file.sv
// reg_file: architectural register file with rename tags (tag 0 = value ready).
//   clk_in      : clock, state updates on posedge
//   rst_in      : asynchronous active-low reset (values, tags, pending_cnt cleared)
//   rdy_in      : global ready; low holds all state
//   bus         : reg_file_if.slave, combinational reads, rename and commit/rollback requests
//   pending_cnt : registered count of registers with a nonzero tag
// Optional: define REG_FILE_BYPASS_EN to forward a same-cycle commit onto the read ports.
module reg_file #(
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TAG_W   = 5
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    reg_file_if.slave   bus,
    output logic [5:0]  pending_cnt
);
    localparam int unsigned IDX_W = 5;
    localparam int unsigned CNT_W = 6;

    logic [XLEN-1:0]  value_q [REG_NUM];
    logic [TAG_W-1:0] tag_q   [REG_NUM];
    logic [XLEN-1:0]  value_d [REG_NUM];
    logic [TAG_W-1:0] tag_d   [REG_NUM];
    logic [CNT_W-1:0] cnt_d;

    // Next state: commit first, then rollback clears or rename overrides the tag.
    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        cnt_d   = '0;
        if (rdy_in) begin
            if (bus.commit_flag && (bus.rd_from_rob != '0)) begin
                value_d[bus.rd_from_rob] = bus.V_from_rob;
                // A younger writer keeps its tag; only the matching producer clears it.
                if (tag_q[bus.rd_from_rob] == bus.Q_from_rob) begin
                    tag_d[bus.rd_from_rob] = '0;
                end
            end
            if (bus.rollback_flag) begin
                for (int unsigned i = 0; i < REG_NUM; i++) begin
                    tag_d[i] = '0;
                end
            end else if (bus.en_signal_from_dispatcher && (bus.rd_from_dispatcher != '0)) begin
                tag_d[bus.rd_from_dispatcher] = bus.rob_id_from_dispatcher;
            end
        end
        for (int unsigned i = 1; i < REG_NUM; i++) begin
            if (tag_d[i] != '0) begin
                cnt_d = cnt_d + CNT_W'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            pending_cnt <= '0;
        end else begin
            value_q     <= value_d;
            tag_q       <= tag_d;
            pending_cnt <= cnt_d;
        end
    end

    // Combinational read of one source; reads the pre-update state of this cycle.
    function automatic logic [TAG_W+XLEN-1:0] read_port(input logic [IDX_W-1:0] rs);
        logic [TAG_W-1:0] q;
        logic [XLEN-1:0]  v;
        q = tag_q[rs];
        v = value_q[rs];
`ifdef REG_FILE_BYPASS_EN
        // Forward only a commit that will actually clear the tag at this edge.
        if (rdy_in && bus.commit_flag && (rs == bus.rd_from_rob) && (tag_q[rs] == bus.Q_from_rob)) begin
            q = '0;
            v = bus.V_from_rob;
        end
`endif
        if (rs == '0) begin
            q = '0;
            v = '0;
        end
        return {q, v};
    endfunction

    always_comb begin
        {bus.Q1_to_dispatcher, bus.V1_to_dispatcher} = read_port(bus.rs1_from_dispatcher);
        {bus.Q2_to_dispatcher, bus.V2_to_dispatcher} = read_port(bus.rs2_from_dispatcher);
    end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed checks of reset, reads, rename, commit, rollback and rdy_in hold.
module tb_reg_file;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       rdy;
    logic [5:0] pending_cnt;
    int         errors = 0;
    int         checks = 0;

    reg_file_if bus ();

    reg_file dut (
        .clk_in      (clk),
        .rst_in      (rst_n),
        .rdy_in      (rdy),
        .bus         (bus),
        .pending_cnt (pending_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.rs1_from_dispatcher       = '0;
        bus.rs2_from_dispatcher       = '0;
        bus.en_signal_from_dispatcher = 1'b0;
        bus.rd_from_dispatcher        = '0;
        bus.rob_id_from_dispatcher    = '0;
        bus.commit_flag               = 1'b0;
        bus.rd_from_rob               = '0;
        bus.Q_from_rob                = '0;
        bus.V_from_rob                = '0;
        bus.rollback_flag             = 1'b0;
        rdy                           = 1'b1;
    endtask

    // Advance one edge, then clear requests; samples happen >= 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic rename(input logic [4:0] rd, input logic [4:0] id);
        bus.en_signal_from_dispatcher = 1'b1;
        bus.rd_from_dispatcher        = rd;
        bus.rob_id_from_dispatcher    = id;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [4:0] q, input logic [31:0] v);
        bus.commit_flag = 1'b1;
        bus.rd_from_rob = rd;
        bus.Q_from_rob  = q;
        bus.V_from_rob  = v;
    endtask

    task automatic read(input logic [4:0] a, input logic [4:0] b);
        bus.rs1_from_dispatcher = a;
        bus.rs2_from_dispatcher = b;
        #1;
    endtask

    initial begin
        idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        read(5'd0, 5'd7);
        check("rst_q1", 32'(bus.Q1_to_dispatcher), 32'd0);
        check("rst_q2", 32'(bus.Q2_to_dispatcher), 32'd0);
        check("rst_v1", bus.V1_to_dispatcher, 32'd0);
        check("rst_v2", bus.V2_to_dispatcher, 32'd0);
        check("rst_pend", 32'(pending_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Commit to x0 is ignored.
        commit(5'd0, 5'd0, 32'hDEADBEEF);
        tick();
        read(5'd0, 5'd0);
        check("x0_v1", bus.V1_to_dispatcher, 32'd0);
        check("x0_q1", 32'(bus.Q1_to_dispatcher), 32'd0);

        // Rename then matching commit.
        rename(5'd5, 5'd3);
        tick();
        read(5'd5, 5'd0);
        check("ren_q1", 32'(bus.Q1_to_dispatcher), 32'd3);
        check("ren_pend", 32'(pending_cnt), 32'd1);
        commit(5'd5, 5'd3, 32'h1234);
        tick();
        read(5'd5, 5'd0);
        check("cmt_q1", 32'(bus.Q1_to_dispatcher), 32'd0);
        check("cmt_v1", bus.V1_to_dispatcher, 32'h1234);
        check("cmt_pend", 32'(pending_cnt), 32'd0);

        // Older commit must not clear a younger tag.
        rename(5'd5, 5'd3);
        tick();
        rename(5'd5, 5'd7);
        tick();
        commit(5'd5, 5'd3, 32'hAA);
        tick();
        read(5'd5, 5'd0);
        check("old_q1", 32'(bus.Q1_to_dispatcher), 32'd7);
        check("old_v1", bus.V1_to_dispatcher, 32'hAA);
        check("old_pend", 32'(pending_cnt), 32'd1);
        commit(5'd5, 5'd7, 32'hBB);
        tick();
        read(5'd5, 5'd0);
        check("young_q1", 32'(bus.Q1_to_dispatcher), 32'd0);
        check("young_v1", bus.V1_to_dispatcher, 32'hBB);

        // Commit and rename to the same rd in one cycle: rename wins the tag.
        rename(5'd9, 5'd4);
        tick();
        commit(5'd9, 5'd4, 32'h55);
        rename(5'd9, 5'd6);
        read(5'd9, 5'd0);
`ifdef REG_FILE_BYPASS_EN
        check("same_rd_q1", 32'(bus.Q1_to_dispatcher), 32'd0);
`else
        check("same_rd_q1", 32'(bus.Q1_to_dispatcher), 32'd4);
`endif
        tick();
        read(5'd9, 5'd0);
        check("both_q1", 32'(bus.Q1_to_dispatcher), 32'd6);
        check("both_v1", bus.V1_to_dispatcher, 32'h55);
        check("both_pend", 32'(pending_cnt), 32'd1);

        // Rollback with concurrent commit and dropped rename.
        rename(5'd1, 5'd2);
        tick();
        rename(5'd2, 5'd3);
        tick();
        rename(5'd3, 5'd4);
        tick();
        check("pre_rb_pend", 32'(pending_cnt), 32'd4);
        bus.rollback_flag = 1'b1;
        commit(5'd1, 5'd2, 32'h40);
        rename(5'd4, 5'd5);
        tick();
        read(5'd1, 5'd4);
        check("rb_q1", 32'(bus.Q1_to_dispatcher), 32'd0);
        check("rb_v1", bus.V1_to_dispatcher, 32'h40);
        check("rb_q4", 32'(bus.Q2_to_dispatcher), 32'd0);
        check("rb_pend", 32'(pending_cnt), 32'd0);
        read(5'd9, 5'd3);
        check("rb_q9", 32'(bus.Q1_to_dispatcher), 32'd0);
        check("rb_q3", 32'(bus.Q2_to_dispatcher), 32'd0);

        // Commit forwarding onto a same-cycle read.
        rename(5'd8, 5'd5);
        tick();
        commit(5'd8, 5'd5, 32'h99);
        read(5'd0, 5'd8);
`ifdef REG_FILE_BYPASS_EN
        check("byp_q2", 32'(bus.Q2_to_dispatcher), 32'd0);
        check("byp_v2", bus.V2_to_dispatcher, 32'h99);
`else
        check("byp_q2", 32'(bus.Q2_to_dispatcher), 32'd5);
        check("byp_v2", bus.V2_to_dispatcher, 32'd0);
`endif
        tick();
        read(5'd0, 5'd8);
        check("post_q2", 32'(bus.Q2_to_dispatcher), 32'd0);
        check("post_v2", bus.V2_to_dispatcher, 32'h99);

        // rdy_in low blocks commit and rename.
        rename(5'd10, 5'd3);
        tick();
        rdy = 1'b0;
        commit(5'd10, 5'd3, 32'h77);
        rename(5'd11, 5'd2);
        tick();
        read(5'd10, 5'd11);
        check("hold_q10", 32'(bus.Q1_to_dispatcher), 32'd3);
        check("hold_v10", bus.V1_to_dispatcher, 32'd0);
        check("hold_q11", 32'(bus.Q2_to_dispatcher), 32'd0);
        check("hold_pend", 32'(pending_cnt), 32'd1);

        // Asynchronous reset mid-run.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        read(5'd5, 5'd10);
        check("arst_v5", bus.V1_to_dispatcher, 32'd0);
        check("arst_q10", 32'(bus.Q2_to_dispatcher), 32'd0);
        check("arst_pend", 32'(pending_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with rename tags for the out-of-order core.
- Upstream: dispatcher reads source operands and tags, and renames rd to a RoB id.
- Downstream: the RoB commit port writes retired values and clears matching tags; the rollback flag squashes all in-flight tags.
- Sits between the dispatcher (read/rename side) and the RoB (commit side).

Parameters:
REG_NUM, 32, number of architectural registers (x0 hardwired to zero)
XLEN, 32, data width
TAG_W, 5, RoB id width; tag 0 = value ready, 1..16 = pending RoB entry

Ports:
clk_in  input  1  clock, all state updates on posedge
rst_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  global ready; when low all state holds
rs1_from_dispatcher  input  5  source register 1 index
rs2_from_dispatcher  input  5  source register 2 index
Q1_to_dispatcher  output  TAG_W  tag of rs1 (0 = ready)
Q2_to_dispatcher  output  TAG_W  tag of rs2
V1_to_dispatcher  output  XLEN  value of rs1 (valid when Q1 = 0)
V2_to_dispatcher  output  XLEN  value of rs2
en_signal_from_dispatcher  input  1  rename request this cycle
rd_from_dispatcher  input  5  destination to rename
rob_id_from_dispatcher  input  TAG_W  RoB id allocated to rd (1..16)
commit_flag  input  1  RoB commit strobe
rd_from_rob  input  5  committed destination
Q_from_rob  input  TAG_W  committed RoB id (head + 1)
V_from_rob  input  XLEN  committed value
rollback_flag  input  1  misprediction flush
pending_cnt  output  6  number of registers with nonzero tag

Behaviour:
- Reset (rst_in low, asynchronous): all values 0, all tags 0, pending_cnt 0. The read outputs are combinational and therefore read 0.
- Reads (combinational):
  - Index 0 always returns Q = 0, V = 0.
  - Otherwise return the stored tag/value, with commit bypass (see Optional Feature).
  - A read of the register being renamed in the same cycle returns the pre-rename state. This lets an instruction read its own rd as a source, e.g. addi x5,x5,1.
- Commit (posedge, rdy_in high, commit_flag high, rd_from_rob != 0):
  - value[rd] <= V_from_rob.
  - tag[rd] <= 0 only if tag[rd] == Q_from_rob; otherwise the tag is kept because a younger writer is pending.
  - rd = 0: ignored entirely.
- Rename (posedge, rdy_in high, en_signal high, rd != 0, rollback_flag low): tag[rd] <= rob_id_from_dispatcher. The value is untouched.
- Commit and rename to the same rd in the same cycle: the value is written from the commit, and the tag takes the rename id (rename wins).
- Rollback (posedge, rdy_in high, rollback_flag high):
  - All tags <= 0.
  - Any rename in the same cycle is dropped.
  - A commit in the same cycle still writes its value, since the RoB raises commit_flag and rollback_flag together for a mispredicted jal/jalr.
- rdy_in low: no writes of any kind. Reads remain combinational on the held state.
- pending_cnt: registered popcount of nonzero tags, updated in the same edge as the tags. It is 0 one cycle after rollback. Max value 31.
- Tags are opaque TAG_W-bit ids and are compared by full equality. No wrap arithmetic is performed here.

Optional Feature:
REG_FILE_BYPASS_EN
- Defined: on a read where commit_flag is high, rs != 0, rs == rd_from_rob and the stored tag == Q_from_rob, the read returns Q = 0 and V = V_from_rob in the same cycle.
- Undefined: reads see only registered state. The dispatcher sees the ready operand one cycle later (RoB ready[] covers correctness).

Test Plan:
- Reset then read x0 and x7 -> Q1 = Q2 = 0, V1 = V2 = 0, pending_cnt = 0. Attempt a commit of rd = 0 with V = 0xDEADBEEF -> x0 still reads 0.
- Rename x5 -> id 3; next cycle read rs1 = x5 -> Q1 = 3, pending_cnt = 1. Commit rd = 5, Q = 3, V = 0x1234 -> next cycle Q1 = 0, V1 = 0x1234, pending_cnt = 0.
- Rename x5 -> 3, then x5 -> 7. Commit rd = 5, Q = 3, V = 0xAA -> value = 0xAA but Q1 stays 7. Commit Q = 7, V = 0xBB -> Q1 = 0, V1 = 0xBB.
- Same cycle: commit rd = 9, Q = 4, V = 0x55 and rename rd = 9 -> id 6 -> next cycle Q = 6, stored value 0x55. Same-cycle read of rs1 = 9 during the rename returns the old tag 4.
- Rename x1 -> 2, x2 -> 3, x3 -> 4, then rollback with commit rd = 1, Q = 2, V = 0x40 plus rename x4 -> 5 in the same cycle -> all tags 0, x1 = 0x40, x4 not renamed, pending_cnt = 0.
- With REG_FILE_BYPASS_EN: tag[x8] = 5, commit rd = 8, Q = 5, V = 0x99 with rs2 = 8 in the same cycle -> Q2 = 0, V2 = 0x99 combinationally. Without the macro -> Q2 = 5 that cycle, 0 the next. With rdy_in low during the commit -> no change.
